spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
SPI mode-0 responder that emulates a minimal serial flash, backed by an internal byte RAM. It is the far end of the single-bit SPI flash link that picosoc drives as master, and serves as a loopback and bring-up target on spare pins. Commands supported: READ (0x03), PAGE PROGRAM (0x02) and READ ID (0x9F). A fabric-side read port exposes the RAM contents for inspection.

Parameters:
ADDR_BITS, 8, RAM depth is 2**ADDR_BITS bytes; the 24-bit SPI address is truncated to its low ADDR_BITS.
JEDEC_ID, 24'hEF4016, value returned by READ ID, MSB first.

Ports:
clk  input  1  system clock; must run at 4x spi_clk or faster.
resetn  input  1  asynchronous active-low reset.
spi_csb  input  1  chip select, active low.
spi_clk  input  1  SPI clock from the master.
spi_mosi  input  1  master-to-responder data.
spi_miso  output  1  responder-to-master data; 0 when not driving.
spi_miso_oe  output  1  output enable for the MISO pad.
busy  output  1  high while synchronised csb is low.
host_addr  input  ADDR_BITS  fabric read address.
host_rdata  output  8  RAM byte at host_addr, registered, 1-cycle latency.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, busy=0, host_rdata=0, state=IDLE, all counters 0. Reset does not clear RAM contents.
- Input synchronisation: spi_csb, spi_clk and spi_mosi each pass through a 2-flop synchroniser. The csb synchroniser resets to 1; the clk and mosi synchronisers reset to 0.
- Edge detection: rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d. Both are ignored while csb_s is high.
- Sampling: spi_mosi is sampled on rise, MSB first, into an 8-bit shift register, and a 3-bit bit counter increments. A byte is complete when the counter wraps from 7 to 0.
- States:
  - IDLE: waiting for csb to fall.
  - CMD: collecting the 8-bit command byte.
  - ADDR: collecting 3 address bytes.
  - RD: streaming RAM bytes to the master.
  - WR: writing received bytes to RAM.
  - ID: streaming JEDEC_ID bytes.
  - IGN: ignoring the rest of the transaction.
- Transitions:
  - IDLE -> CMD when csb_s is low.
  - CMD -> ADDR on byte complete with 0x03 or 0x02.
  - CMD -> ID on 0x9F.
  - CMD -> IGN on any other command byte.
  - ADDR -> RD (0x03) or WR (0x02) after the 3rd address byte.
  - Any state -> IDLE within one clk after csb_s goes high.
- Address: the byte pointer is loaded from addr[ADDR_BITS-1:0] and increments modulo 2**ADDR_BITS after every data byte, so the last byte is followed by byte 0.
- Read path:
  - The RAM read of the current pointer is issued on the rise that completes the last address byte, or the last bit of the previous data byte.
  - On the following fall, the byte is loaded into the MISO shift register and bit 7 is driven.
  - Each subsequent fall shifts out the next bit.
  - spi_miso_oe=1 in RD and ID from the first data fall until csb_s goes high; 0 in every other state.
- ID: bytes JEDEC_ID[23:16], [15:8], [7:0] are sent in order, followed by 0x00 for any further bytes.
- Write path:
  - Each completed data byte is written to RAM[ptr] on the clk following byte completion, then ptr increments.
  - A partial byte at csb rise is discarded.
- csb rise mid-operation: MISO stops driving (oe=0, miso=0), the bit counter clears, and no partial write occurs.
- csb falling and rising within fewer than 2 clks may be missed; this is the master's responsibility.
- host_rdata is updated every clk from RAM[host_addr]. A simultaneous SPI write to the same address returns the old value on that cycle.

Optional Feature:
- Macro SPI_FLASH_RESPONDER_FAST_READ_EN.
- When defined: adds FAST READ (0x0B), with a DUMMY state after ADDR that discards exactly 8 spi_clk cycles before entering RD. Timing in RD is identical to 0x03.
- When undefined: 0x0B is an unknown command and goes to IGN, with MISO undriven.

Test Plan:
- Reset with csb high -> spi_miso=0, spi_miso_oe=0, busy=0, host_rdata=0.
- 02 00 00 10, then A5 3C -> host_addr=0x10 reads 0xA5 and host_addr=0x11 reads 0x3C, one cycle after the address is applied.
- 03 00 00 10, clock 16 bits -> MISO returns A5 3C MSB first, with oe high only during the data bytes.
- 9F, clock 32 bits -> EF 40 16 00.
- Wrap-around: write 11 22 starting at address 0xFF (ADDR_BITS=8) -> RAM[0xFF]=0x11, RAM[0x00]=0x22. Reading from 0xFF returns 11 22.
- Abort and unknown command: csb rises after 5 bits of a data byte in WR -> that byte is not written. Command 0x55 -> oe stays 0 for the whole frame. With FAST_READ_EN: 0B 00 00 10 plus 8 dummy clocks -> A5.

Source files
------------

// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
//   SPI mode-0 responder that looks like a minimal serial flash to the master.
//   It is backed by an internal byte RAM of 2**ADDR_BITS entries. Supported
//   commands: READ (0x03), PAGE PROGRAM (0x02) and READ ID (0x9F). A
//   fabric-side port reads the RAM for inspection.
//
//   Optional feature: define SPI_FLASH_RESPONDER_FAST_READ_EN to add FAST
//   READ (0x0B). It discards one dummy byte (8 spi_clk cycles) after the
//   address. Without the macro, 0x0B is treated as an unknown command.
//
// Parameters
//   ADDR_BITS   RAM depth is 2**ADDR_BITS bytes (SPI address truncated)
//   JEDEC_ID    24-bit value returned by READ ID, MSB first
//
// Ports
//   clk          system clock, at least 4x spi_clk
//   resetn       asynchronous active-low reset
//   spi_csb      chip select from master, active low
//   spi_clk      SPI clock from master
//   spi_mosi     master-to-responder data
//   spi_miso     responder-to-master data, 0 when not driving
//   spi_miso_oe  MISO pad output enable
//   busy         high while synchronised csb is low
//   host_addr    fabric read address
//   host_rdata   RAM[host_addr], registered, 1-cycle latency
// -----------------------------------------------------------------------------
module spi_flash_responder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 spi_csb,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic                 busy,
    input  logic [ADDR_BITS-1:0] host_addr,
    output logic [7:0]           host_rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, RD, WR, ID, IGN
    } state_t;

    state_t state, state_nxt;

    logic csb_m, csb_s;
    logic sclk_m, sclk_s, sclk_d;
    logic mosi_m, mosi_s;

    logic [2:0]           bit_cnt;
    logic [1:0]           byte_cnt;
    logic [ADDR_BITS-1:0] ptr;
    logic                 oe;
    logic                 wr_pend;

    logic [6:0]           shift_in;
    logic [7:0]           cmd;
    logic [7:0]           wr_byte;
    logic [7:0]           rd_byte;
    logic [7:0]           miso_sr;
    logic [7:0]           ram [DEPTH];

    logic                 rise, fall, byte_done;
    logic [7:0]           rx_byte;
    logic [ADDR_BITS-1:0] addr_next;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [7:0]           id_byte;

    assign rise      = sclk_s & ~sclk_d & ~csb_s;
    assign fall      = ~sclk_s & sclk_d & ~csb_s;
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign rx_byte   = {shift_in, mosi_s};
    // Address bytes shift in MSB first; only the low ADDR_BITS survive.
    assign addr_next = ADDR_BITS'({ptr, rx_byte});

    assign busy        = ~csb_s;
    assign spi_miso_oe = oe;
    assign spi_miso    = oe & miso_sr[7];

    always_comb begin
        state_nxt = state;
        if (csb_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            8'h03, 8'h02: state_nxt = ADDR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                            8'h0B:        state_nxt = ADDR;
`endif
                            8'h9F:        state_nxt = ID;
                            default:      state_nxt = IGN;
                        endcase
                    end
                end
                ADDR: begin
                    if (byte_done && byte_cnt == 2'd2) begin
                        if (cmd == 8'h02)
                            state_nxt = WR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                        else if (cmd == 8'h0B)
                            state_nxt = DUMMY;
`endif
                        else
                            state_nxt = RD;
                    end
                end
                DUMMY: if (byte_done) state_nxt = RD;
                default: ;
            endcase
        end
    end

    // RAM read for the next outgoing byte is launched on the rise that
    // completes the preceding byte so it is ready by the following fall.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = ptr;
        if (byte_done) begin
            case (state)
                ADDR: if (byte_cnt == 2'd2) begin
                    rd_en   = 1'b1;
                    rd_addr = addr_next;
                end
                DUMMY: rd_en = 1'b1;
                RD: begin
                    rd_en   = 1'b1;
                    rd_addr = ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (byte_cnt)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csb_m      <= 1'b1;
            csb_s      <= 1'b1;
            sclk_m     <= 1'b0;
            sclk_s     <= 1'b0;
            sclk_d     <= 1'b0;
            mosi_m     <= 1'b0;
            mosi_s     <= 1'b0;
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 2'd0;
            ptr        <= '0;
            oe         <= 1'b0;
            wr_pend    <= 1'b0;
            host_rdata <= 8'h00;
        end else begin
            csb_m      <= spi_csb;
            csb_s      <= csb_m;
            sclk_m     <= spi_clk;
            sclk_s     <= sclk_m;
            sclk_d     <= sclk_s;
            mosi_m     <= spi_mosi;
            mosi_s     <= mosi_m;
            state      <= state_nxt;
            host_rdata <= ram[host_addr];

            if (csb_s) begin
                bit_cnt <= 3'd0;
                oe      <= 1'b0;
            end else begin
                if (rise)
                    bit_cnt <= bit_cnt + 3'd1;
                if (fall && (state == RD || state == ID))
                    oe <= 1'b1;
            end

            // byte_cnt counts address bytes in ADDR and ID bytes sent in ID.
            if (state != state_nxt)
                byte_cnt <= 2'd0;
            else if (byte_done && state == ADDR)
                byte_cnt <= byte_cnt + 2'd1;
            else if (fall && bit_cnt == 3'd0 && state == ID && byte_cnt != 2'd3)
                byte_cnt <= byte_cnt + 2'd1;

            if (byte_done && state == ADDR)
                ptr <= addr_next;
            else if (byte_done && state == RD)
                ptr <= ptr + 1'b1;
            else if (wr_pend)
                ptr <= ptr + 1'b1;

            // A completed byte is committed even if csb rises right after.
            wr_pend <= byte_done && (state == WR);
        end
    end

    always_ff @(posedge clk) begin
        if (rise)
            shift_in <= {shift_in[5:0], mosi_s};
        if (byte_done && state == CMD)
            cmd <= rx_byte;
        if (byte_done && state == WR)
            wr_byte <= rx_byte;
        if (wr_pend)
            ram[ptr] <= wr_byte;
        if (rd_en)
            rd_byte <= ram[rd_addr];
        // A fall with bit_cnt == 0 follows a completed byte: load the next one.
        if (fall) begin
            if (bit_cnt == 3'd0)
                miso_sr <= (state == ID) ? id_byte : rd_byte;
            else
                miso_sr <= {miso_sr[6:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// -----------------------------------------------------------------------------
// Testbench for spi_flash_responder: directed SPI frames followed by
// randomized write/read-back frames, compared against a byte-array model.
// -----------------------------------------------------------------------------
module tb_spi_flash_responder;

    localparam int          HALF = 6;
    localparam logic [23:0] JID  = 24'hEF4016;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       spi_csb = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe, busy;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];
    bit         oe_all [16];
    bit         oe_any [16];
    bit         miso_stray;
    bit         busy_mid;

    logic [7:0] mem    [256];
    bit         mvalid [256];

    always #5 clk = ~clk;

    spi_flash_responder #(.ADDR_BITS(8), .JEDEC_ID(JID)) dut (
        .clk(clk), .resetn(resetn),
        .spi_csb(spi_csb), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy),
        .host_addr(host_addr), .host_rdata(host_rdata)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_hdr(input logic [7:0] c, input logic [23:0] a);
        tx_buf[0] = c;
        tx_buf[1] = a[23:16];
        tx_buf[2] = a[15:8];
        tx_buf[3] = a[7:0];
    endtask

    // One csb-low frame of n bytes; the last byte carries only last_bits bits.
    task automatic do_frame(input int n, input int last_bits);
        miso_stray = 0;
        @(negedge clk);
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
        busy_mid = busy;
        for (int b = 0; b < n; b++) begin
            int nb = (b == n - 1) ? last_bits : 8;
            rx_buf[b] = 8'h00;
            oe_all[b] = 1;
            oe_any[b] = 0;
            for (int i = 7; i >= 8 - nb; i--) begin
                spi_mosi = tx_buf[b][i];
                repeat (HALF) @(negedge clk);
                rx_buf[b][i] = spi_miso;
                if (spi_miso_oe) oe_any[b] = 1;
                else begin
                    oe_all[b] = 0;
                    if (spi_miso) miso_stray = 1;
                end
                spi_clk = 1'b1;
                repeat (HALF) @(negedge clk);
                spi_clk = 1'b0;
            end
        end
        repeat (HALF) @(negedge clk);
        spi_csb = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic host_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        host_addr = a;
        @(negedge clk);
        check(tag, host_rdata, exp);
    endtask

    // Model: a page program stores data bytes at consecutive addresses mod 256.
    task automatic model_write(input logic [7:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            mem[8'(a + i)]    = tx_buf[4 + i];
            mvalid[8'(a + i)] = 1;
        end
    endtask

    initial begin
        logic [23:0] ra;
        int          len;

        for (int i = 0; i < 256; i++) mvalid[i] = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_miso", {7'd0, spi_miso}, 8'h00);
        check("rst_oe", {7'd0, spi_miso_oe}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_hrdata", host_rdata, 8'h00);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", {7'd0, busy}, 8'h00);

        // Page program A5 3C at 0x10
        set_hdr(8'h02, 24'h000010);
        tx_buf[4] = 8'hA5; tx_buf[5] = 8'h3C;
        do_frame(6, 8);
        model_write(8'h10, 2);
        check("wr_busy_mid", {7'd0, busy_mid}, 8'h01);
        check("wr_oe_any", {7'd0, oe_any[4] | oe_any[5]}, 8'h00);
        host_check("host_10", 8'h10, mem[8'h10]);
        host_check("host_11", 8'h11, mem[8'h11]);

        // Read back 2 bytes
        set_hdr(8'h03, 24'h000010);
        tx_buf[4] = 8'h00; tx_buf[5] = 8'h00;
        do_frame(6, 8);
        for (int b = 0; b < 4; b++)
            check($sformatf("rd_hdr_oe%0d", b), {7'd0, oe_any[b]}, 8'h00);
        check("rd_d0", rx_buf[4], mem[8'h10]);
        check("rd_d1", rx_buf[5], mem[8'h11]);
        check("rd_d0_oe", {7'd0, oe_all[4]}, 8'h01);
        check("rd_d1_oe", {7'd0, oe_all[5]}, 8'h01);
        check("rd_post_oe", {7'd0, spi_miso_oe}, 8'h00);

        // READ ID
        tx_buf[0] = 8'h9F;
        for (int b = 1; b < 5; b++) tx_buf[b] = 8'h00;
        do_frame(5, 8);
        check("id0", rx_buf[1], JID[23:16]);
        check("id1", rx_buf[2], JID[15:8]);
        check("id2", rx_buf[3], JID[7:0]);
        check("id3", rx_buf[4], 8'h00);
        check("id_oe", {7'd0, oe_all[1] & oe_all[4]}, 8'h01);

        // Wrap-around at the top of the RAM
        set_hdr(8'h02, 24'h0000FF);
        tx_buf[4] = 8'h11; tx_buf[5] = 8'h22;
        do_frame(6, 8);
        model_write(8'hFF, 2);
        host_check("wrap_ff", 8'hFF, mem[8'hFF]);
        host_check("wrap_00", 8'h00, mem[8'h00]);
        set_hdr(8'h03, 24'h0000FF);
        tx_buf[4] = 8'h00; tx_buf[5] = 8'h00;
        do_frame(6, 8);
        check("wrap_rd0", rx_buf[4], 8'h11);
        check("wrap_rd1", rx_buf[5], 8'h22);

        // Abort in WR: full byte kept, partial byte dropped
        set_hdr(8'h02, 24'h000021);
        tx_buf[4] = 8'h5A;
        do_frame(5, 8);
        model_write(8'h21, 1);
        set_hdr(8'h02, 24'h000020);
        tx_buf[4] = 8'h77; tx_buf[5] = 8'hC3;
        do_frame(6, 5);
        model_write(8'h20, 1);
        host_check("abort_20", 8'h20, mem[8'h20]);
        host_check("abort_21", 8'h21, 8'h5A);

        // Unknown command: MISO never driven
        tx_buf[0] = 8'h55; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h00; tx_buf[3] = 8'hAA;
        do_frame(4, 8);
        check("unk_oe", {7'd0, oe_any[0] | oe_any[1] | oe_any[2] | oe_any[3]}, 8'h00);
        check("unk_miso", {7'd0, miso_stray}, 8'h00);

        // FAST READ (0x0B)
        set_hdr(8'h0B, 24'h000010);
        tx_buf[4] = 8'h00; tx_buf[5] = 8'h00;
        do_frame(6, 8);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        check("fast_dummy_oe", {7'd0, oe_any[4]}, 8'h00);
        check("fast_d0", rx_buf[5], mem[8'h10]);
        check("fast_d0_oe", {7'd0, oe_all[5]}, 8'h01);
`else
        check("fast_off_oe", {7'd0, oe_any[4] | oe_any[5]}, 8'h00);
        check("fast_off_miso", {7'd0, miso_stray}, 8'h00);
`endif

        // Randomized write / read-back, full 24-bit addresses
        for (int it = 0; it < 6; it++) begin
            ra  = 24'($urandom);
            len = $urandom_range(5, 1);
            set_hdr(8'h02, ra);
            for (int i = 0; i < len; i++) tx_buf[4 + i] = 8'($urandom);
            do_frame(4 + len, 8);
            model_write(ra[7:0], len);

            set_hdr(8'h03, ra);
            for (int i = 0; i <= len; i++) tx_buf[4 + i] = 8'($urandom);
            do_frame(5 + len, 8);
            for (int i = 0; i <= len; i++) begin
                if (mvalid[8'(ra[7:0] + i)])
                    check($sformatf("rnd%0d_rd%0d", it, i), rx_buf[4 + i], mem[8'(ra[7:0] + i)]);
            end
            host_check($sformatf("rnd%0d_host", it), ra[7:0], mem[ra[7:0]]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
